// File: rtl/reg_table_pkg.sv
// Shared definitions for the register-table engine.
//   state_t        : command FSM states
//   ADDR_NUM_IMG   : read-only address that fetches the image count
//   ADDR_IMG_SIZE  : read-only address that fetches one image size
//   ERR_WORD       : response for a read of an unmapped address
//   TIMEOUT_CYC    : WAIT budget in cycles (used only with REG_TABLE_TIMEOUT_EN)
package reg_table_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   localparam logic [7:0]  ADDR_NUM_IMG  = 8'hF0;
   localparam logic [7:0]  ADDR_IMG_SIZE = 8'hF1;
   localparam logic [31:0] ERR_WORD      = 32'hDEADBEEF;
   localparam logic [15:0] TIMEOUT_CYC   = 16'd1000;

   function automatic logic is_mem_addr(input logic [7:0] addr);
      return (addr == ADDR_NUM_IMG) || (addr == ADDR_IMG_SIZE);
   endfunction

endpackage

// File: rtl/reg_table_rsp_byte_serializer.sv
// Response byte serializer: loads a RSP_BYTES-wide word and streams it out
// MSB byte first over a valid/ready handshake.
// Ports:
//   sysClk, rst           clock, synchronous active-high reset
//   load, word            capture a new response (only while idle)
//   byte_out_ready        downstream accepts the current byte
//   byte_out, byte_out_valid, byte_out_last   byte stream
//   done                  handshake on the final byte this cycle
module rsp_byte_serializer #(
   parameter int RSP_BYTES = 4
) (
   input  logic                   sysClk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [RSP_BYTES*8-1:0] word,
   input  logic                   byte_out_ready,
   output logic [7:0]             byte_out,
   output logic                   byte_out_valid,
   output logic                   byte_out_last,
   output logic                   done
);

   localparam int RSP_W = RSP_BYTES * 8;
   localparam int CNT_W = $clog2(RSP_BYTES) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_BYTES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [RSP_W-1:0] shreg;
   // bytes still to send; zero means nothing pending
   logic [CNT_W-1:0] cnt;
   logic             take;

   assign byte_out       = shreg[RSP_W-1 -: 8];
   assign byte_out_valid = (cnt != '0);
   assign byte_out_last  = (cnt == CNT_ONE);
   assign take           = byte_out_valid & byte_out_ready;
   assign done           = take & byte_out_last;

   always_ff @(posedge sysClk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= word;
         cnt   <= CNT_FULL;
      end else if (take) begin
         // decrement only while non-zero, so the counter never wraps
         shreg <= shreg << 8;
         cnt   <= cnt - CNT_ONE;
      end
   end

endmodule

// File: rtl/reg_table_engine.sv
// Register-table command engine: local read/write registers plus two
// remote read-only addresses answered by a memory interface. Read responses
// are returned as a RSP_BYTES-long byte stream, MSB first.
// Optional feature macro: REG_TABLE_TIMEOUT_EN -- abort WAIT after
// TIMEOUT_CYC cycles, answer 0xFF bytes and pulse rsp_err.
// Ports:
//   sysClk, rst                      clock, synchronous active-high reset
//   reg_addr, reg_data, reg_input_valid, cmd_ready   command port
//   jpg_size(_valid), num_both_img(_valid)           memory replies
//   read_num_img, read_img_size, img_index           memory requests
//   byte_out, byte_out_valid, byte_out_ready, byte_out_last  response stream
//   rsp_err                          illegal address / timeout pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; local writes complete here
// REQ     | one-cycle request pulse to the memory interface
// WAIT    | waiting for the matching memory reply
// SEND    | serializer streaming the response bytes
module reg_table_engine
   import reg_table_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int DATA_W    = 16,
   parameter int RSP_BYTES = 4
) (
   input  logic              sysClk,
   input  logic              rst,
   input  logic [7:0]        reg_addr,
   input  logic [DATA_W:0]   reg_data,
   input  logic              reg_input_valid,
   output logic              cmd_ready,
   input  logic [31:0]       jpg_size,
   input  logic              jpg_size_valid,
   input  logic [31:0]       num_both_img,
   input  logic              num_both_img_valid,
   output logic              read_num_img,
   output logic              read_img_size,
   output logic [15:0]       img_index,
   output logic [7:0]        byte_out,
   output logic              byte_out_valid,
   input  logic              byte_out_ready,
   output logic              byte_out_last,
   output logic              rsp_err
);

   localparam int RSP_W = RSP_BYTES * 8;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0] NUM_REGS_9 = 9'(NUM_REGS);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [DATA_W-1:0]   payload;
   logic                is_read;
   logic                accept;
   logic                addr_local;
   logic [IDX_W-1:0]    rd_idx;
   logic                req_size_q;
   logic                reply_valid;
   logic [31:0]         reply;
   logic                load;
   logic [RSP_W-1:0]    load_word;
   logic                err_d;
   logic                rsp_err_q;
   logic [15:0]         img_index_q;
   logic                done;
   logic                tmo_hit;

   assign payload     = reg_data[DATA_W-1:0];
   assign is_read     = reg_data[DATA_W];
   assign accept      = reg_input_valid & cmd_ready;
   assign addr_local  = ({1'b0, reg_addr} < NUM_REGS_9);
   assign rd_idx      = reg_addr[IDX_W-1:0];
   // only the reply matching the outstanding request counts
   assign reply_valid = req_size_q ? jpg_size_valid : num_both_img_valid;
   assign reply       = req_size_q ? jpg_size : num_both_img;
   assign rsp_err     = rsp_err_q;
   assign img_index   = img_index_q;

`ifdef REG_TABLE_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // loaded in REQ so WAIT lasts exactly TIMEOUT_CYC cycles before abort
   always_ff @(posedge sysClk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state_q == ST_REQ) begin
         tmo_cnt <= TIMEOUT_CYC - 16'd1;
      end else if ((state_q == ST_WAIT) && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 16'd1;
      end
   end

   assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt == '0);
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cmd_ready     = 1'b0;
      read_num_img  = 1'b0;
      read_img_size = 1'b0;
      load          = 1'b0;
      load_word     = '0;
      err_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (reg_input_valid) begin
               if (!is_read) begin
                  err_d = !addr_local;
               end else if (addr_local) begin
                  load      = 1'b1;
                  load_word = RSP_W'(regs[rd_idx]);
                  state_d   = ST_SEND;
               end else if (is_mem_addr(reg_addr)) begin
                  state_d = ST_REQ;
               end else begin
                  load      = 1'b1;
                  load_word = RSP_W'(ERR_WORD);
                  err_d     = 1'b1;
                  state_d   = ST_SEND;
               end
            end
         end
         ST_REQ: begin
            read_img_size = req_size_q;
            read_num_img  = !req_size_q;
            if (reply_valid) begin
               load      = 1'b1;
               load_word = RSP_W'(reply);
               state_d   = ST_SEND;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (reply_valid) begin
               load      = 1'b1;
               load_word = RSP_W'(reply);
               state_d   = ST_SEND;
            end else if (tmo_hit) begin
               load      = 1'b1;
               load_word = '1;
               err_d     = 1'b1;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysClk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rsp_err_q   <= 1'b0;
         req_size_q  <= 1'b0;
         img_index_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state_q   <= state_d;
         rsp_err_q <= err_d;
         if (accept) begin
            req_size_q <= (reg_addr == ADDR_IMG_SIZE);
            if (!is_read && addr_local) regs[rd_idx] <= payload;
            if (is_read && (reg_addr == ADDR_IMG_SIZE)) img_index_q <= 16'(payload);
         end
      end
   end

   rsp_byte_serializer #(
      .RSP_BYTES (RSP_BYTES)
   ) u_ser (
      .sysClk         (sysClk),
      .rst            (rst),
      .load           (load),
      .word           (load_word),
      .byte_out_ready (byte_out_ready),
      .byte_out       (byte_out),
      .byte_out_valid (byte_out_valid),
      .byte_out_last  (byte_out_last),
      .done           (done)
   );

endmodule
